regfile_writeback: RTL and testbench

Sequencer that owns the write side of the RV32I register file (drives we/waddr/wdata). Merges single-cycle ALU results with variable-latency load data returned by the LSU. Load data is held in a small in-order FIFO. Tracks destinations of in-flight loads in a busy scoreboard used by issue logic for RAW/WAW stalls.

---
 rtl/regfile_writeback.sv | 146 ++++++++++++++
 tb/tb_regfile_writeback.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Write-back sequencer for the RV32I register file: merges ALU results with buffered load returns
// and keeps a busy scoreboard of in-flight load destinations. Define WB_FWD_EN to add write forwarding ports.
module regfile_writeback #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [4:0]    lsu_rd,
    input  logic [31:0]   lsu_data,
    input  logic          ld_issue_valid,
    input  logic [4:0]    ld_issue_rd,
    output logic          ld_issue_ready,
    output logic [31:0]   busy_mask,
    output logic [CW-1:0] fifo_count,
    output logic          we,
    output logic [4:0]    waddr,
    output logic [31:0]   wdata
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]    fwd_raddr1,
    input  logic [4:0]    fwd_raddr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [31:0]   fwd_data1,
    output logic [31:0]   fwd_data2
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   busy_reg;
    logic [31:0]   busy_next;
    logic          we_reg;
    logic [4:0]    waddr_reg;
    logic [31:0]   wdata_reg;

    logic          push;
    logic          pop;
    logic          issue_take;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    // Ready is based on the registered count, so a full FIFO stays not-ready even while popping.
    assign lsu_ready  = (count_reg != CW'(DEPTH));
    assign push       = lsu_valid && lsu_ready;
    assign pop        = !alu_valid && (count_reg != '0);
    assign head_rd    = rd_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];

    assign ld_issue_ready = !busy_reg[ld_issue_rd];
    assign issue_take     = ld_issue_valid && ld_issue_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= lsu_rd;
            data_mem[wr_ptr_reg] <= lsu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // x0 is never reserved; a set and clear of the same register cannot coincide since issue sees busy=1.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                logic set_bit;
                logic clr_bit;
                assign set_bit       = issue_take && (ld_issue_rd == 5'(gi));
                assign clr_bit       = pop && (head_rd == 5'(gi));
                assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // ALU results take the port unconditionally; the FIFO head only drains in ALU-idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else if (alu_valid) begin
            we_reg    <= (alu_rd != 5'd0);
            waddr_reg <= alu_rd;
            wdata_reg <= alu_data;
        end else if (pop) begin
            we_reg    <= (head_rd != 5'd0);
            waddr_reg <= head_rd;
            wdata_reg <= head_data;
        end else begin
            we_reg    <= 1'b0;
        end
    end

    assign busy_mask  = busy_reg;
    assign fifo_count = count_reg;
    assign we         = we_reg;
    assign waddr      = waddr_reg;
    assign wdata      = wdata_reg;

`ifdef WB_FWD_EN
    assign fwd_hit1  = we_reg && (waddr_reg == fwd_raddr1) && (waddr_reg != 5'd0);
    assign fwd_hit2  = we_reg && (waddr_reg == fwd_raddr2) && (waddr_reg != 5'd0);
    assign fwd_data1 = wdata_reg;
    assign fwd_data2 = wdata_reg;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DEPTH=4); forwarding checks only with WB_FWD_EN.
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_rd;
    logic [31:0]   lsu_data;
    logic          ld_issue_valid;
    logic [4:0]    ld_issue_rd;
    logic          ld_issue_ready;
    logic [31:0]   busy_mask;
    logic [CW-1:0] fifo_count;
    logic          we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
`ifdef WB_FWD_EN
    logic [4:0]    fwd_raddr1;
    logic [4:0]    fwd_raddr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [31:0]   fwd_data1;
    logic [31:0]   fwd_data2;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_rd         (lsu_rd),
        .lsu_data       (lsu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .busy_mask      (busy_mask),
        .fifo_count     (fifo_count),
        .we             (we),
        .waddr          (waddr),
        .wdata          (wdata)
`ifdef WB_FWD_EN
        ,
        .fwd_raddr1     (fwd_raddr1),
        .fwd_raddr2     (fwd_raddr2),
        .fwd_hit1       (fwd_hit1),
        .fwd_hit2       (fwd_hit2),
        .fwd_data1      (fwd_data1),
        .fwd_data2      (fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic chk_wr(input string tag, input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data);
        chk({tag, "_we"}, 32'(we), 32'(e_we));
        if (e_we) begin
            chk({tag, "_waddr"}, 32'(waddr), 32'(e_addr));
            chk({tag, "_wdata"}, wdata, e_data);
        end
        $display("step %-10s we=%0d waddr=%0d wdata=%h count=%0d busy=%h ready=%0d",
                 tag, we, waddr, wdata, fifo_count, busy_mask, lsu_ready);
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        ld_issue_valid = 1'b0; ld_issue_rd = '0;
`ifdef WB_FWD_EN
        fwd_raddr1 = '0; fwd_raddr2 = '0;
`endif
        tick();
        tick();
        chk_wr("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_ready", 32'(lsu_ready), 32'd1);
        reset = 1'b0;

        // ALU write appears one cycle later for exactly one cycle; x0 is suppressed
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        tick();
        chk_wr("alu5", 1'b1, 5'd5, 32'hDEAD_BEEF);
        alu_valid = 1'b0;
        tick();
        chk_wr("alu5_off", 1'b0, 5'd0, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1111_2222;
        tick();
        chk_wr("alu_x0", 1'b0, 5'd0, 32'd0);
        alu_valid = 1'b0;

        // Reserve x1..x4
        ld_issue_valid = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            ld_issue_rd = 5'(r);
            #1;
            chk("iss_ready", 32'(ld_issue_ready), 32'd1);
            tick();
        end
        ld_issue_valid = 1'b0;
        chk("busy_1to4", busy_mask, 32'h0000_001E);

        // Fill FIFO while ALU holds the port
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_00A0;
        lsu_valid = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            lsu_rd = 5'(r); lsu_data = 32'(r * 8'h11);
            tick();
            chk("fill_count", 32'(fifo_count), 32'(r));
        end
        lsu_valid = 1'b0;
        chk("full_ready", 32'(lsu_ready), 32'd0);
        chk_wr("full_alu", 1'b1, 5'd10, 32'h0000_00A0);
        tick();
        chk("full_hold", 32'(fifo_count), 32'd4);
        chk_wr("full_alu2", 1'b1, 5'd10, 32'h0000_00A0);

        // Drain in push order once the ALU goes idle
        alu_valid = 1'b0;
        tick();
        chk_wr("drain1", 1'b1, 5'd1, 32'h0000_0011);
        chk("drain1_cnt", 32'(fifo_count), 32'd3);
        chk("drain1_rdy", 32'(lsu_ready), 32'd1);
        chk("drain1_busy", busy_mask, 32'h0000_001C);
        tick();
        chk_wr("drain2", 1'b1, 5'd2, 32'h0000_0022);
        chk("drain2_busy", busy_mask, 32'h0000_0018);
        tick();
        chk_wr("drain3", 1'b1, 5'd3, 32'h0000_0033);
        tick();
        chk_wr("drain4", 1'b1, 5'd4, 32'h0000_0044);
        chk("drain4_cnt", 32'(fifo_count), 32'd0);
        chk("drain4_busy", busy_mask, 32'd0);
        tick();
        chk_wr("drain_idle", 1'b0, 5'd0, 32'd0);

        // Single load to x7: scoreboard and two-cycle latency
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
        tick();
        chk("x7_busy", busy_mask, 32'h0000_0080);
        #1;
        chk("x7_notready", 32'(ld_issue_ready), 32'd0);
        ld_issue_rd = 5'd0;
        #1;
        chk("x0_ready", 32'(ld_issue_ready), 32'd1);
        ld_issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_1234;
        tick();
        lsu_valid = 1'b0;
        chk_wr("x7_nobypass", 1'b0, 5'd0, 32'd0);
        chk("x7_count", 32'(fifo_count), 32'd1);
        chk("x7_busy_hold", busy_mask, 32'h0000_0080);
        tick();
        chk_wr("x7_write", 1'b1, 5'd7, 32'h0000_1234);
        chk("x7_busy_clr", busy_mask, 32'd0);

        // Simultaneous push and pop at count=2
        ld_issue_valid = 1'b1;
        ld_issue_rd = 5'd8;  tick();
        ld_issue_rd = 5'd9;  tick();
        ld_issue_rd = 5'd11; tick();
        ld_issue_valid = 1'b0;
        chk("pp_busy", busy_mask, 32'h0000_0B00);
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h0000_00C0;
        lsu_valid = 1'b1;
        lsu_rd = 5'd8; lsu_data = 32'h0000_0088; tick();
        lsu_rd = 5'd9; lsu_data = 32'h0000_0099; tick();
        chk("pp_count2", 32'(fifo_count), 32'd2);
        alu_valid = 1'b0;
        lsu_rd = 5'd11; lsu_data = 32'h0000_00BB;
        tick();
        lsu_valid = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'd2);
        chk_wr("pp_pop8", 1'b1, 5'd8, 32'h0000_0088);
        tick();
        chk_wr("pp_pop9", 1'b1, 5'd9, 32'h0000_0099);
        tick();
        chk_wr("pp_pop11", 1'b1, 5'd11, 32'h0000_00BB);
        chk("pp_empty", 32'(fifo_count), 32'd0);
        chk("pp_busy_clr", busy_mask, 32'd0);

        // x0 load still consumes its entry but never writes
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
        tick();
        ld_issue_valid = 1'b0;
        chk("x0_nores", busy_mask, 32'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_00FF;
        tick();
        lsu_valid = 1'b0;
        chk("x0_push", 32'(fifo_count), 32'd1);
        tick();
        chk_wr("x0_pop", 1'b0, 5'd0, 32'd0);
        chk("x0_popcnt", 32'(fifo_count), 32'd0);

`ifdef WB_FWD_EN
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_CAFE;
        fwd_raddr1 = 5'd9; fwd_raddr2 = 5'd0;
        tick();
        alu_valid = 1'b0;
        chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
        chk("fwd_data1", fwd_data1, 32'h0000_CAFE);
        chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
        fwd_raddr2 = 5'd9;
        #1;
        chk("fwd_hit2b", 32'(fwd_hit2), 32'd1);
        tick();
        chk("fwd_idle", 32'(fwd_hit1), 32'd0);
`endif

        // Asynchronous reset with three loads buffered and x2/x5 reserved
        ld_issue_valid = 1'b1;
        ld_issue_rd = 5'd2; tick();
        ld_issue_rd = 5'd5; tick();
        ld_issue_valid = 1'b0;
        chk("mr_busy", busy_mask, 32'h0000_0024);
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h0000_0D0D;
        lsu_valid = 1'b1;
        lsu_rd = 5'd2; lsu_data = 32'h0000_0202; tick();
        lsu_rd = 5'd5; lsu_data = 32'h0000_0505; tick();
        lsu_rd = 5'd0; lsu_data = 32'h0000_0000; tick();
        lsu_valid = 1'b0;
        alu_valid = 1'b0;
        chk("mr_count3", 32'(fifo_count), 32'd3);
        chk_wr("mr_pre", 1'b1, 5'd13, 32'h0000_0D0D);
        #2;
        reset = 1'b1;
        #1;
        chk_wr("mr_async", 1'b0, 5'd0, 32'd0);
        chk("mr_count", 32'(fifo_count), 32'd0);
        chk("mr_busy0", busy_mask, 32'd0);
        chk("mr_ready", 32'(lsu_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        chk_wr("mr_after", 1'b0, 5'd0, 32'd0);
        chk("mr_after_cnt", 32'(fifo_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
